muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Initiator side of the multiply/divide unit interface. It accepts a mult/div request from the control unit and latches the operands. It drives the unit's 2-bit control code for exactly the iteration count the unit needs, then captures the unit's Hi/Lo into the architectural HI/LO registers. It also detects divide-by-zero, serves mfhi/mflo reads and mthi/mtlo writes, and enforces the idle gap the unit needs between operations.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 32, cycles the control code is held for a multiply
DIV_CYCLES, 33, cycles the control code is held for a divide

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request strobe from control unit, sampled in IDLE
op  in  2  01 = mult, 10 = div; 00/11 illegal
a_in, b_in  in  WIDTH  operands, sampled with start
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse (also on div-zero abort)
div_zero  out  1  one-cycle pulse, coincident with done, on divide by zero
unit_ctrl  out  2  control code to mult/div unit (registered)
unit_a, unit_b  out  WIDTH  operands to unit, held stable for whole operation
unit_hi, unit_lo  in  WIDTH  unit result registers
unit_divzero  in  1  unit divide-by-zero flag
hi_we, lo_we  in  1  mthi / mtlo write enables
wdata  in  WIDTH  mthi/mtlo data
hi_out, lo_out  out  WIDTH  architectural HI/LO (mfhi/mflo read)

Behaviour:
- Reset (sync, any state, mid-op included): state=IDLE; counter=0; unit_ctrl=00; unit_a/unit_b=0; hi_out/lo_out=0; busy/done/div_zero=0.
- States: IDLE, RUN, CAPTURE.
- IDLE:
  - start=1 with op in {01,10} at edge E0: latch op, a_in→unit_a, b_in→unit_b; counter=0; state=RUN.
  - unit_ctrl=op from the cycle after E0. busy=1 from the cycle after E0.
  - start with op 00/11 is ignored; stay IDLE.
- RUN:
  - unit_ctrl=op held; counter increments each edge.
  - After N active cycles (N = MULT_CYCLES or DIV_CYCLES): unit_ctrl←00, state=CAPTURE.
  - unit_ctrl is high for exactly N consecutive cycles.
- CAPTURE (unit_ctrl=00, busy=1):
  - At its edge: hi_out←unit_hi, lo_out←unit_lo; done=1 next cycle; state=IDLE.
  - Latency: start sampled at end of cycle k; done and updated HI/LO visible in cycle k+N+2 (mult k+34, div k+35).
  - busy is high cycles k+1..k+N+1.
- Div-zero:
  - Only for op=10, and only when counter==1, i.e. cycle k+2, the first cycle after the unit's first active edge.
  - If unit_divzero=1: unit_ctrl←00, state=IDLE, done=1 and div_zero=1 in cycle k+3; hi_out/lo_out unchanged.
  - unit_divzero in cycle k+1 is stale from the prior op and is ignored. unit_divzero is ignored for mult.
- Idle gap: unit_ctrl is guaranteed 00 for at least one cycle before any new nonzero code, since the done cycle and the CAPTURE/abort edge drive 00.
  - start accepted in the done cycle drives unit_ctrl nonzero in the following cycle. This is legal.
- Busy rules:
  - start while busy: ignored, no queueing.
  - hi_we/lo_we while busy: ignored.
- mthi/mtlo (not busy): hi_we writes wdata to hi_out, lo_we writes wdata to lo_out, both at the edge; both may be set together.
  - Write and start in the same IDLE cycle: the write takes effect; the later capture overwrites it.
- hi_out/lo_out change only on capture, mthi/mtlo write, or reset.
- done and div_zero are never high for more than one cycle.

Test Plan:
- Bench pairs with the team's mult/div unit (or a cycle-accurate model).
- mult a=7, b=-3 (0xFFFFFFFD), start at cycle k → unit_ctrl=01 cycles k+1..k+32; done in k+34; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- div a=100, b=7 → unit_ctrl=10 for 33 cycles; done in k+35; lo_out=14, hi_out=2; div a=-100, b=7 → lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2).
- div a=5, b=0 (preceded by HI=0x11, LO=0x22 via mthi/mtlo) → done and div_zero in k+3, unit_ctrl 00 from k+3, HI/LO stay 0x11/0x22; a following mult yields no spurious div_zero.
- reset pulsed in cycle k+10 of a mult → next cycle busy=0, unit_ctrl=00, hi_out=lo_out=0, no done pulse; fresh mult then completes with correct result.
- Back-to-back: second start in done cycle → unit_ctrl 00 for ≥1 cycle between ops; start and hi_we asserted mid-op are ignored (HI unchanged, no extra done).

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - mult/div unit initiator: operand latch, control-code sequencing, HI/LO capture
module muldiv_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [1:0]       o_unit_ctrl,
  output logic [WIDTH-1:0] o_unit_a,
  output logic [WIDTH-1:0] o_unit_b,
  input  logic [WIDTH-1:0] i_unit_hi,
  input  logic [WIDTH-1:0] i_unit_lo,
  input  logic             i_unit_divzero,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_hi_out,
  output logic [WIDTH-1:0] o_lo_out
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_ctrl;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_unit_a;
  logic [WIDTH-1:0] r_unit_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [CW-1:0] w_last;
  logic          w_op_ok;
  logic          w_dz_abort;

  assign w_last     = (r_op == OP_DIV) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
  assign w_op_ok    = (i_op == OP_MULT) || (i_op == OP_DIV);
  // The unit's flag is only meaningful after its first active edge; earlier it is stale.
  assign w_dz_abort = (r_op == OP_DIV) && (r_cnt == CW'(1)) && i_unit_divzero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_op       <= 2'b00;
      r_cnt      <= '0;
      r_ctrl     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_unit_a   <= '0;
      r_unit_b   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (i_start && w_op_ok) begin
            r_op     <= i_op;
            r_unit_a <= i_a_in;
            r_unit_b <= i_b_in;
            r_cnt    <= '0;
            r_ctrl   <= i_op;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_dz_abort) begin
            r_ctrl     <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
            r_state    <= IDLE;
          end else if (r_cnt == w_last) begin
            r_ctrl  <= 2'b00;
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_hi    <= i_unit_hi;
          r_lo    <= i_unit_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;
  assign o_unit_ctrl = r_ctrl;
  assign o_unit_a    = r_unit_a;
  assign o_unit_b    = r_unit_b;
  assign o_hi_out    = r_hi;
  assign o_lo_out    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer with a behavioural mult/div unit
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_in = '0, b_in = '0;
  logic        busy, done, div_zero;
  logic [1:0]  u_ctrl;
  logic [31:0] u_a, u_b;
  logic [31:0] u_hi = '0, u_lo = '0;
  logic        u_dz = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int cyc;} exp_t;
  typedef struct {logic [1:0] code; int len;} run_t;
  exp_t sb[$];
  run_t runs[$];

  muldiv_sequencer #(.WIDTH(32), .MULT_CYCLES(32), .DIV_CYCLES(33)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
    .i_a_in(a_in), .i_b_in(b_in),
    .o_busy(busy), .o_done(done), .o_div_zero(div_zero),
    .o_unit_ctrl(u_ctrl), .o_unit_a(u_a), .o_unit_b(u_b),
    .i_unit_hi(u_hi), .i_unit_lo(u_lo), .i_unit_divzero(u_dz),
    .i_hi_we(hi_we), .i_lo_we(lo_we), .i_wdata(wdata),
    .o_hi_out(hi_out), .o_lo_out(lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural unit: result settles on active edges, divzero flag persists until the next active edge.
  always @(posedge clk) begin
    logic signed [63:0] sa, sbv, p;
    sa  = {{32{u_a[31]}}, u_a};
    sbv = {{32{u_b[31]}}, u_b};
    if (u_ctrl == 2'b01) begin
      p = sa * sbv;
      u_hi <= p[63:32];
      u_lo <= p[31:0];
      u_dz <= 1'b0;
    end else if (u_ctrl == 2'b10) begin
      if (u_b == 32'd0) begin
        u_dz <= 1'b1;
      end else begin
        u_lo <= $signed(u_a) / $signed(u_b);
        u_hi <= $signed(u_a) % $signed(u_b);
        u_dz <= 1'b0;
      end
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    exp_t e;
    if (div_zero && !done) chk("dz_without_done", 32'(div_zero), 32'(done));
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("hi_out", hi_out, e.hi);
        chk("lo_out", lo_out, e.lo);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Control-code run monitor
  int run_len = 0;
  logic [1:0] run_code = 2'b00;
  always @(negedge clk) begin
    run_t r;
    if (u_ctrl != 2'b00) begin
      if (run_len == 0) run_code = u_ctrl;
      else if (u_ctrl != run_code) chk("ctrl_no_gap", 32'(u_ctrl), 32'(run_code));
      run_len++;
    end else if (run_len > 0) begin
      if (runs.size() == 0) begin
        chk("unexpected_ctrl_run", 32'(run_len), 32'd0);
      end else begin
        r = runs.pop_front();
        chk("ctrl_code", 32'(run_code), 32'(r.code));
        chk("ctrl_len", 32'(run_len), 32'(r.len));
      end
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic sb_en, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int lat, input int len);
    exp_t e;
    run_t r;
    start = 1'b1; op = o; a_in = a; b_in = b;
    if (sb_en) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    r.code = o; r.len = len;
    runs.push_back(r);
    tick();
    start = 1'b0; op = 2'b00;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && (sb.size() != 0 || runs.size() != 0); i++) tick();
    if (sb.size() != 0 || runs.size() != 0) begin
      chk("drain_timeout", 32'(sb.size() + runs.size()), 32'd0);
      sb.delete();
      runs.delete();
    end
  endtask

  initial begin
    int k;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ctrl", 32'(u_ctrl), 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_unit_a", u_a, 0);
    chk("rst_unit_b", u_b, 0);

    // Illegal op codes are ignored
    start = 1'b1; op = 2'b00; tick();
    chk("illegal00_busy", 32'(busy), 0);
    op = 2'b11; tick();
    chk("illegal11_busy", 32'(busy), 0);
    chk("illegal11_ctrl", 32'(u_ctrl), 0);
    start = 1'b0; op = 2'b00;

    issue(2'b01, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34, 32);
    chk("mult_busy", 32'(busy), 1);
    chk("mult_unit_b", u_b, 32'hFFFF_FFFD);
    drain();

    // Write in the start cycle lands, then capture overwrites it
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    issue(2'b10, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 35, 33);
    hi_we = 1'b0;
    chk("start_write_hi", hi_out, 32'h0000_ABCD);
    drain();

    issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0, 35, 33);
    drain();

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11; tick();
    lo_we = 1'b1; hi_we = 1'b0; wdata = 32'h22; tick();
    lo_we = 1'b0;
    chk("mthi", hi_out, 32'h11);
    chk("mtlo", lo_out, 32'h22);

    issue(2'b10, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1, 3, 2);
    drain();
    chk("dz_ctrl_idle", 32'(u_ctrl), 0);
    // Stale divzero from the aborted op must not abort the next divide
    issue(2'b10, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1, 3, 2);
    drain();
    issue(2'b10, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 35, 33);
    drain();
    issue(2'b10, 32'd5, 32'd0, 1, 32'd2, 32'd14, 1, 3, 2);
    drain();
    issue(2'b01, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34, 32);
    drain();

    // Reset mid-multiply: reset high in cycle k+10
    issue(2'b01, 32'd3, 32'd4, 0, 0, 0, 0, 0, 10);
    repeat (9) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ctrl", 32'(u_ctrl), 0);
    chk("midrst_hi", hi_out, 0);
    chk("midrst_lo", lo_out, 0);
    chk("midrst_done", 32'(done), 0);
    repeat (40) tick();
    drain();
    issue(2'b01, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0, 34, 32);
    drain();

    // Back-to-back: second start in the done cycle
    issue(2'b01, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 34, 32);
    k = 0;
    while (!done && k < 60) begin tick(); k++; end
    chk("b2b_done_seen", 32'(done), 1);
    chk("b2b_ctrl_gap", 32'(u_ctrl), 0);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0, 35, 33);
    drain();

    // Start and mthi/mtlo while busy are ignored
    issue(2'b01, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 34, 32);
    repeat (4) tick();
    start = 1'b1; op = 2'b10; a_in = 32'd1; b_in = 32'd1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
    tick();
    start = 1'b0; op = 2'b00; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_we_hi", hi_out, 32'hFFFF_FFFE);
    chk("busy_we_lo", lo_out, 32'hFFFF_FFF2);
    chk("busy_start_unit_a", u_a, 32'd6);
    drain();
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
